// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_checker
//  Description : Reads word 0 (ID) and word 1 (timestamp) from an Avalon-MM
//                system-ID slave, compares each against the expected value
//                and reports the result. A read that stalls for too many
//                consecutive cycles ends the sequence with a timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1647009701,
  parameter int unsigned TIMEOUT_CYCLES     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // Counter value seen on the last allowed stalled edge of a read.
  localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_ID = 2'd1,
    S_RD_TS = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_wait_cnt;
  logic        r_id_ok;
  logic        r_ts_ok;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;
  logic        w_stall_expired;

  // A stalled edge that would exceed the allowed wait budget.
  assign w_stall_expired = avm_waitrequest && (r_wait_cnt == C_TIMEOUT_LAST);

  assign id_ok    = r_id_ok;
  assign ts_ok    = r_ts_ok;
  assign timeout  = r_timeout;
  assign id_value = r_id_value;
  assign ts_value = r_ts_value;

  // State register; reset drops the bus strobe immediately via the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; bus and status outputs decode straight from the state
  // so they cannot change while the slave is stalling.
  always_comb begin
    w_state_next = r_state;
    avm_read     = 1'b0;
    avm_address  = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RD_ID;
        end
      end
      S_RD_ID: begin
        avm_read = 1'b1;
        busy     = 1'b1;
        if (!avm_waitrequest) begin
          w_state_next = S_RD_TS;
        end else if (w_stall_expired) begin
          w_state_next = S_DONE;
        end
      end
      S_RD_TS: begin
        avm_read    = 1'b1;
        avm_address = 1'b1;
        busy        = 1'b1;
        if (!avm_waitrequest || w_stall_expired) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Result capture, comparison flags and per-read stall counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= 16'd0;
      r_id_ok    <= 1'b0;
      r_ts_ok    <= 1'b0;
      r_timeout  <= 1'b0;
      r_id_value <= 32'd0;
      r_ts_value <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_wait_cnt <= 16'd0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= 32'd0;
            r_ts_value <= 32'd0;
          end
        end
        S_RD_ID, S_RD_TS: begin
          if (!avm_waitrequest) begin
            if (r_state == S_RD_ID) begin
              r_id_value <= avm_readdata;
              r_id_ok    <= (avm_readdata == EXPECTED_ID);
              r_wait_cnt <= 16'd0;
            end else begin
              r_ts_value <= avm_readdata;
              r_ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
            // A timed-out sequence never reports a match, even if the ID
            // word had already compared equal.
            if (w_stall_expired) begin
              r_timeout <= 1'b1;
              r_id_ok   <= 1'b0;
              r_ts_ok   <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sysid_checker
//  Description : Self-checking bench for sysid_checker with a configurable
//                wait-state Avalon-MM slave and a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sysid_checker;

  localparam int          T  = 16;
  localparam logic [31:0] TS = 32'd1647009701;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  // Slave configuration, driven by the stimulus
  logic [31:0] id_data;
  logic [31:0] ts_data;
  int          id_w;
  int          ts_w;

  // Slave / monitor state
  int   stall;
  int   cur_w;
  int   acc_id;
  int   acc_ts;
  int   stab_err;
  logic prev_stall;
  logic prev_addr;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] idd;
    logic [31:0] tsd;
    int          idw;
    int          tsw;
    int          lat;
    logic        idok;
    logic        tsok;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
    int          nid;
    int          nts;
  } vec_t;

  sysid_checker #(
    .EXPECTED_ID       (32'd0),
    .EXPECTED_TIMESTAMP(TS),
    .TIMEOUT_CYCLES    (T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  always #5 clock = ~clock;

  // Slave: stalls each read for the configured number of cycles.
  always_comb begin
    cur_w           = avm_address ? ts_w : id_w;
    avm_waitrequest = avm_read && (stall < cur_w);
    avm_readdata    = avm_address ? ts_data : id_data;
  end

  always @(posedge clock) begin
    if (!avm_read || !avm_waitrequest) stall <= 0;
    else                               stall <= stall + 1;
    if (avm_read && !avm_waitrequest) begin
      if (avm_address) acc_ts <= acc_ts + 1;
      else             acc_id <= acc_id + 1;
    end
  end

  // Address must not move while the previous cycle was stalled.
  always @(negedge clock) begin
    if (prev_stall && avm_read && (avm_address != prev_addr)) stab_err <= stab_err + 1;
    prev_stall <= avm_read && avm_waitrequest;
    prev_addr  <= avm_address;
  end

  initial begin
    stall = 0; acc_id = 0; acc_ts = 0; stab_err = 0;
    prev_stall = 1'b0; prev_addr = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference model: outcome of one sequence from the slave behaviour.
  function automatic vec_t model(input logic [31:0] idd, input logic [31:0] tsd,
                                 input int idw, input int tsw);
    vec_t r;
    r.idd = idd; r.tsd = tsd; r.idw = idw; r.tsw = tsw;
    r.idok = 1'b0; r.tsok = 1'b0; r.to = 1'b0;
    r.idv = 32'd0; r.tsv = 32'd0; r.nid = 0; r.nts = 0;
    if (idw >= T) begin
      r.to = 1'b1; r.lat = T + 1;
    end else if (tsw >= T) begin
      r.to = 1'b1; r.lat = idw + T + 2; r.idv = idd; r.nid = 1;
    end else begin
      r.lat = idw + tsw + 3;
      r.idv = idd; r.tsv = tsd; r.nid = 1; r.nts = 1;
      r.idok = (idd == 32'd0);
      r.tsok = (tsd == TS);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] idd, input logic [31:0] tsd, input int idw,
                              input int tsw, input int lat, input logic idok, input logic tsok,
                              input logic to, input logic [31:0] idv, input logic [31:0] tsv,
                              input int nid, input int nts);
    vec_t r;
    r.idd = idd; r.tsd = tsd; r.idw = idw; r.tsw = tsw; r.lat = lat;
    r.idok = idok; r.tsok = tsok; r.to = to; r.idv = idv; r.tsv = tsv;
    r.nid = nid; r.nts = nts;
    return r;
  endfunction

  // Wait for done with a bound; returns latency in cycles after the start edge.
  task automatic wait_done(output int lat, output int rd_cyc, output bit seen);
    lat = 0; rd_cyc = 0; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clock);
      lat++;
      if (avm_read) rd_cyc++;
      if (done) seen = 1;
    end
  endtask

  task automatic run_seq(input vec_t v, input bit hold);
    int lat, rd_cyc, a0, a1, s0;
    bit seen;
    @(negedge clock);
    id_data = v.idd; ts_data = v.tsd; id_w = v.idw; ts_w = v.tsw;
    a0 = acc_id; a1 = acc_ts; s0 = stab_err;
    start = 1'b1;
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
    wait_done(lat, rd_cyc, seen);
    check("done_seen", 32'(seen), 32'd1);
    check("latency", lat, v.lat);
    check("id_ok", 32'(id_ok), 32'(v.idok));
    check("ts_ok", 32'(ts_ok), 32'(v.tsok));
    check("timeout", 32'(timeout), 32'(v.to));
    check("id_value", id_value, v.idv);
    check("ts_value", ts_value, v.tsv);
    check("read_cycles", rd_cyc, v.lat - 1);
    check("id_reads", acc_id - a0, v.nid);
    check("ts_reads", acc_ts - a1, v.nts);
    check("addr_stable", stab_err - s0, 32'd0);
    @(negedge clock);
    check("done_pulse_end", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;
    int lat, rd_cyc, a0, a1, cnt;
    bit seen;

    tbl[0] = mk(32'd0, TS, 0, 0, 3, 1, 1, 0, 32'd0, TS, 1, 1);
    tbl[1] = mk(32'd0, TS, 2, 2, 7, 1, 1, 0, 32'd0, TS, 1, 1);
    tbl[2] = mk(32'd0, 32'h12345678, 0, 0, 3, 1, 0, 0, 32'd0, 32'h12345678, 1, 1);
    tbl[3] = mk(32'd0, TS, 1000, 0, 17, 0, 0, 1, 32'd0, 32'd0, 0, 0);
    tbl[4] = mk(32'd1, TS, 1, 0, 4, 0, 1, 0, 32'd1, TS, 1, 1);
    tbl[5] = mk(32'd0, TS, 15, 15, 33, 1, 1, 0, 32'd0, TS, 1, 1);
    tbl[6] = mk(32'd5, TS, 3, 16, 21, 0, 0, 1, 32'd5, 32'd0, 1, 0);
    tbl[7] = mk(32'd0, TS, 16, 0, 17, 0, 0, 1, 32'd0, 32'd0, 0, 0);

    reset = 1'b1; start = 1'b0;
    id_data = 32'd0; ts_data = TS; id_w = 0; ts_w = 0;
    repeat (3) @(negedge clock);
    check("rst_read", 32'(avm_read), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    check("rst_values", id_value | ts_value, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_read", 32'(avm_read), 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++) run_seq(tbl[i], 1'b0);

    // Reset during a timestamp stall
    @(negedge clock);
    id_data = 32'hA5A5A5A5; ts_data = TS; id_w = 0; ts_w = 1000;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_rd_ts", {30'd0, avm_read, avm_address}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_read", 32'(avm_read), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
    check("arst_id_value", id_value, 32'd0);
    cnt = 0;
    repeat (2) begin
      @(negedge clock);
      if (done || avm_read) cnt++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (done || busy) cnt++;
    end
    check("arst_no_done", cnt, 32'd0);
    run_seq(tbl[0], 1'b0);

    // Start held high: one read per address, re-arm only via IDLE
    run_seq(tbl[1], 1'b1);
    @(negedge clock);
    check("hold_restart", {30'd0, busy, avm_address}, 32'd2);
    start = 1'b0;
    a0 = acc_id; a1 = acc_ts;
    wait_done(lat, rd_cyc, seen);
    check("hold_done_seen", 32'(seen), 32'd1);
    check("hold_latency", lat, 32'd6);
    check("hold_reads", (acc_id - a0) * 16 + (acc_ts - a1), 32'd17);
    check("hold_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
    @(negedge clock);
    @(negedge clock);
    check("hold_stays_idle", 32'(busy), 32'd0);

    // Randomized sequences against the reference model
    for (int i = 0; i < 40; i++) begin
      rv = model(($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0,
                 ($urandom_range(0, 3) == 0) ? 32'($urandom) : TS,
                 int'($urandom_range(0, 18)), int'($urandom_range(0, 18)));
      run_seq(rv, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
